pipe_ctrl: RTL and testbench

Pipeline controller that sequences the instruction fetch stage. It selects the next-PC source, freezes fetch on load-use hazards, and squashes wrong-path instructions after a taken jump or branch. On a misaligned fetch it halts the pipeline in a trap state. It sits beside the fetch stage and drives fetch's `target` and `bubble` inputs, plus the squash control for the fetch→decode boundary.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/pipe_ctrl_event_counter.sv | 18 +
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: fetch next-PC select and fetch-controller FSM states.
package riscv;

  typedef enum logic [1:0] {
    JALR_TGT,
    JAL_BXX_TGT,
    PC_PLUS4_TGT
  } target_t;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_FLUSH,
    CTRL_STALL,
    CTRL_TRAP
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_event_counter.sv
// Wrapping event counter with synchronous active-low clear and increment enable.
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch-stage sequencer: next-PC select, load-use freeze, wrong-path squash and
// a sticky trap on misaligned fetch.
module pipe_ctrl
  import riscv::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             jalr,
  input  logic             jal,
  input  logic             br_taken,
  input  logic             load_use,
  input  logic             misaligned,
  output target_t          target,
  output logic             bubble,
  output logic             squash,
  output logic             trap,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
    $error("pipe_ctrl: FLUSH_CYCLES must be in 1..7");
  end
  if (STALL_CYCLES < 1 || STALL_CYCLES > 7) begin : g_bad_stall
    $error("pipe_ctrl: STALL_CYCLES must be in 1..7");
  end

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  ctrl_state_t state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        rd;
  logic        rd_acc;

  assign rd = jalr | jal | br_taken;

  always_ff @(posedge clk) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    target    = PC_PLUS4_TGT;
    bubble    = 1'b0;
    squash    = 1'b0;
    trap      = 1'b0;
    rd_acc    = 1'b0;

    if (jalr)
      target = JALR_TGT;
    else if (jal | br_taken)
      target = JAL_BXX_TGT;

    unique case (state)
      CTRL_RUN, CTRL_STALL: begin
        // A redirect raises squash, which masks a misaligned fetch on the wrong path.
        if (misaligned && !rd) begin
          bubble    = 1'b1;
          squash    = 1'b1;
          trap      = 1'b1;
          state_nxt = CTRL_TRAP;
          cnt_nxt   = '0;
        end else if (rd) begin
          squash    = 1'b1;
          rd_acc    = 1'b1;
          state_nxt = (FLUSH_CYCLES > 1) ? CTRL_FLUSH : CTRL_RUN;
          cnt_nxt   = FLUSH_INIT;
        end else if (state == CTRL_RUN) begin
          if (load_use) begin
            bubble    = 1'b1;
            state_nxt = (STALL_CYCLES > 1) ? CTRL_STALL : CTRL_RUN;
            cnt_nxt   = STALL_INIT;
          end
        end else begin
          bubble  = 1'b1;
          cnt_nxt = cnt - 3'd1;
          if (cnt <= 3'd1)
            state_nxt = CTRL_RUN;
        end
      end
      CTRL_FLUSH: begin
        squash = 1'b1;
        if (rd) begin
          rd_acc  = 1'b1;
          cnt_nxt = FLUSH_INIT;
        end else begin
          cnt_nxt = cnt - 3'd1;
          if (cnt <= 3'd1)
            state_nxt = CTRL_RUN;
        end
      end
      CTRL_TRAP: begin
        target = PC_PLUS4_TGT;
        bubble = 1'b1;
        squash = 1'b1;
        trap   = 1'b1;
      end
    endcase

    if (!resetn) begin
      state_nxt = CTRL_RUN;
      cnt_nxt   = '0;
      target    = PC_PLUS4_TGT;
      bubble    = 1'b0;
      squash    = 1'b1;
      trap      = 1'b0;
      rd_acc    = 1'b0;
    end
  end

  event_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk     (clk),
    .clear_n (resetn),
    .en      (rd_acc),
    .count   (redirect_cnt)
  );

  event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_n (resetn),
    .en      (bubble & ~trap),
    .count   (stall_cnt)
  );

  a_jalr_exclusive: assert property (@(posedge clk) disable iff (!resetn)
    !(jalr && (jal || br_taken)));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (FLUSH_CYCLES=2, STALL_CYCLES=2): each driven cycle
// pushes its hand-derived expected outputs, which are popped and compared once sampled.
module tb_pipe_ctrl;
  import riscv::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        jalr = 1'b0, jal = 1'b0, br_taken = 1'b0, load_use = 1'b0, misaligned = 1'b0;
  target_t     target;
  logic        bubble, squash, trap;
  logic [31:0] redirect_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    target_t     tgt;
    logic        bub;
    logic        sq;
    logic        trp;
    logic [31:0] rc;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_CYCLES(2), .CNT_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .jalr         (jalr),
    .jal          (jal),
    .br_taken     (br_taken),
    .load_use     (load_use),
    .misaligned   (misaligned),
    .target       (target),
    .bubble       (bubble),
    .squash       (squash),
    .trap         (trap),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs: {resetn, jalr, jal, br_taken, load_use, misaligned}; counters are the
  // values held before this cycle's clock edge.
  task automatic applyStimulus(input string tag, input logic [5:0] in, input target_t tgt,
                               input logic bub, input logic sq, input logic trp,
                               input int rc, input int sc);
    exp_t e;
    exp_t got;
    @(negedge clk);
    {resetn, jalr, jal, br_taken, load_use, misaligned} = in;
    e.tag = tag; e.tgt = tgt; e.bub = bub; e.sq = sq; e.trp = trp;
    e.rc = 32'(rc); e.sc = 32'(sc);
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      checkOutput({got.tag, ".target"}, 64'(target), 64'(got.tgt));
      checkOutput({got.tag, ".bubble"}, 64'(bubble), 64'(got.bub));
      checkOutput({got.tag, ".squash"}, 64'(squash), 64'(got.sq));
      checkOutput({got.tag, ".trap"}, 64'(trap), 64'(got.trp));
      checkOutput({got.tag, ".redirect_cnt"}, 64'(redirect_cnt), 64'(got.rc));
      checkOutput({got.tag, ".stall_cnt"}, 64'(stall_cnt), 64'(got.sc));
    end
  endtask

  localparam logic [5:0] IDLE = 6'b100000;
  localparam logic [5:0] RST  = 6'b000000;
  localparam logic [5:0] JALR = 6'b110000;
  localparam logic [5:0] JAL  = 6'b101000;
  localparam logic [5:0] BR   = 6'b100100;
  localparam logic [5:0] LU   = 6'b100010;
  localparam logic [5:0] MIS  = 6'b100001;

  initial begin
    $display("[TB] starting pipe_ctrl bench");
    applyStimulus("rst0", RST, PC_PLUS4_TGT, 0, 1, 0, 0, 0);
    applyStimulus("rst_jal", 6'b001000, PC_PLUS4_TGT, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("idle", IDLE, PC_PLUS4_TGT, 0, 0, 0, 0, 0);

    applyStimulus("jal_T", JAL, JAL_BXX_TGT, 0, 1, 0, 0, 0);
    applyStimulus("jal_T1", IDLE, PC_PLUS4_TGT, 0, 1, 0, 1, 0);
    applyStimulus("jal_T2", IDLE, PC_PLUS4_TGT, 0, 0, 0, 1, 0);

    applyStimulus("br_T", BR, JAL_BXX_TGT, 0, 1, 0, 1, 0);
    applyStimulus("br_T1", BR, JAL_BXX_TGT, 0, 1, 0, 2, 0);
    applyStimulus("br_T2", IDLE, PC_PLUS4_TGT, 0, 1, 0, 3, 0);
    applyStimulus("br_T3", IDLE, PC_PLUS4_TGT, 0, 0, 0, 3, 0);

    applyStimulus("lu_T", LU, PC_PLUS4_TGT, 1, 0, 0, 3, 0);
    applyStimulus("lu_T1", IDLE, PC_PLUS4_TGT, 1, 0, 0, 3, 1);
    applyStimulus("lu_T2", IDLE, PC_PLUS4_TGT, 0, 0, 0, 3, 2);

    applyStimulus("jalr_lu_T", 6'b110010, JALR_TGT, 0, 1, 0, 3, 2);
    applyStimulus("jalr_lu_T1", IDLE, PC_PLUS4_TGT, 0, 1, 0, 4, 2);
    applyStimulus("jalr_lu_T2", IDLE, PC_PLUS4_TGT, 0, 0, 0, 4, 2);

    applyStimulus("abort_lu", LU, PC_PLUS4_TGT, 1, 0, 0, 4, 2);
    applyStimulus("abort_jalr", JALR, JALR_TGT, 0, 1, 0, 4, 3);
    applyStimulus("abort_T2", IDLE, PC_PLUS4_TGT, 0, 1, 0, 5, 3);
    applyStimulus("abort_T3", IDLE, PC_PLUS4_TGT, 0, 0, 0, 5, 3);

    applyStimulus("mis_jal", 6'b101001, JAL_BXX_TGT, 0, 1, 0, 5, 3);
    applyStimulus("mis_in_flush", MIS, PC_PLUS4_TGT, 0, 1, 0, 6, 3);
    applyStimulus("mis_flush_end", IDLE, PC_PLUS4_TGT, 0, 0, 0, 6, 3);

    applyStimulus("trap_T", MIS, PC_PLUS4_TGT, 1, 1, 1, 6, 3);
    applyStimulus("trap_jalr", JALR, PC_PLUS4_TGT, 1, 1, 1, 6, 3);
    applyStimulus("trap_lu", LU, PC_PLUS4_TGT, 1, 1, 1, 6, 3);
    applyStimulus("trap_jalr2", JALR, PC_PLUS4_TGT, 1, 1, 1, 6, 3);
    applyStimulus("trap_rst", RST, PC_PLUS4_TGT, 0, 1, 0, 6, 3);
    applyStimulus("trap_after", IDLE, PC_PLUS4_TGT, 0, 0, 0, 0, 0);

    applyStimulus("rstf_jal", JAL, JAL_BXX_TGT, 0, 1, 0, 0, 0);
    applyStimulus("rstf_rst", RST, PC_PLUS4_TGT, 0, 1, 0, 1, 0);
    applyStimulus("rstf_after", IDLE, PC_PLUS4_TGT, 0, 0, 0, 0, 0);

    applyStimulus("rsts_lu", LU, PC_PLUS4_TGT, 1, 0, 0, 0, 0);
    applyStimulus("rsts_rst", RST, PC_PLUS4_TGT, 0, 1, 0, 0, 1);
    applyStimulus("rsts_after", IDLE, PC_PLUS4_TGT, 0, 0, 0, 0, 0);
    applyStimulus("rsts_after2", IDLE, PC_PLUS4_TGT, 0, 0, 0, 0, 0);

    applyStimulus("smis_lu", LU, PC_PLUS4_TGT, 1, 0, 0, 0, 0);
    applyStimulus("smis_mis", MIS, PC_PLUS4_TGT, 1, 1, 1, 0, 1);
    applyStimulus("smis_hold", IDLE, PC_PLUS4_TGT, 1, 1, 1, 0, 1);

    if (sb.size() != 0)
      checkOutput("sb_leftover", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
